// File: rtl/serial_frame_pkg.sv
// serial_frame_pkg
//   Shared definitions for the serial frame receiver and its matching
//   transmitter: the frame state encoding and the default frame geometry.
//   Optional feature macro used by the users of this package:
//   SERIAL_RX_PARITY_EN (adds one even-parity bit after the data bits).
package serial_frame_pkg;

  // Frame states shared by both ends of the link.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT
  } frame_state_e;

  // Default frame geometry: 16x oversampling, 8 data bits.
  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_W       = 8;

endpackage

// File: rtl/serial_rx_sync.sv
// serial_rx_sync
//   Two-flop synchronizer bringing an asynchronous line into the clk domain.
//   The reset value is a parameter so an idle-high line synchronizes to 1.
//   Ports:
//     clk_i   system clock, rising edge
//     rst_ni  synchronous active-low reset
//     d_i     asynchronous input
//     q_o     synchronized output, two cycles of latency
module serial_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second
  // gives it a full cycle to settle before the FSM looks at it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx
//   Serial frame receiver. Oversamples an idle-high asynchronous line,
//   finds the start bit, samples DATA_W data bits LSB first at mid-bit,
//   checks the stop bit and presents each byte on a valid/ready register.
//   Optional feature macro: SERIAL_RX_PARITY_EN adds an even-parity bit
//   after the data bits and the parity_err_o port.
//   Ports:
//     clk_i         system clock, rising edge
//     rst_ni        synchronous active-low reset
//     rx_in_i       raw serial line, idle high, asynchronous
//     data_out_o    last received byte
//     data_valid_o  data_out_o holds an unconsumed byte
//     data_ready_i  consumer takes the byte when valid and ready
//     frame_err_o   one-cycle pulse, stop bit sampled low
//     overrun_o     one-cycle pulse, byte dropped because output was full
//     parity_err_o  one-cycle pulse with the load of a bad-parity byte
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = DEFAULT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_in_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              data_valid_o,
  input  logic              data_ready_i,
  output logic              frame_err_o,
`ifdef SERIAL_RX_PARITY_EN
  output logic              parity_err_o,
`endif
  output logic              overrun_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  logic rx_s;

  frame_state_e      state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;
  logic              deliver;
`ifdef SERIAL_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              perr_q, perr_d;
`endif

  serial_rx_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (rx_in_i),
    .q_o   (rx_s)
  );

  // Frame FSM plus output register next-state. The bit counter runs freely
  // and is cleared on every state change; the output register logic sits
  // after the FSM so a delivery in the same cycle as a consumption wins.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;
    deliver   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        idx_d     = '0;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rx_s) begin
          state_d = START;
        end
      end
      START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d = '0;
          idx_d     = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_cnt_q == FULL_LAST) begin
          bit_cnt_d      = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        // Even parity: the parity bit equals the XOR of the data bits.
        if (bit_cnt_q == FULL_LAST) begin
          bit_cnt_d = '0;
          par_bad_d = rx_s ^ (^shift_q);
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_cnt_q == FULL_LAST) begin
          bit_cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Hold off until a break condition releases the line.
        bit_cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        bit_cnt_d = '0;
        idx_d     = '0;
        state_d   = IDLE;
      end
    endcase

    if (valid_q && data_ready_i) begin
      valid_d = 1'b0;
    end

    // A byte is accepted when the register is empty or being emptied now;
    // otherwise the new byte is dropped and the old one is kept.
    if (deliver) begin
      if (!valid_q || data_ready_i) begin
        data_d  = shift_q;
        valid_d = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
        perr_d  = par_bad_q;
`endif
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // State, counters, shift register and the registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
`ifdef SERIAL_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_out_o   = data_q;
  assign data_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
`ifdef SERIAL_RX_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
//   Directed bench for serial_frame_rx at default geometry. Frames are driven
//   bit by bit on the line; each frame that should produce an output event
//   pushes its expected record into a queue, and a monitor on the falling
//   clock edge pops and compares whenever the DUT shows an event (valid
//   rising or any flag pulse). Honours SERIAL_RX_PARITY_EN like the design.
module tb_serial_frame_rx;

  localparam int CPB = 16;
  localparam int DW  = 8;
`ifdef SERIAL_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int LAT    = 3 + CPB / 2 + (DW + 2) * CPB;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int LAT    = 3 + CPB / 2 + (DW + 1) * CPB;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic          ready = 1'b0;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic          ferr;
  logic          ovr;
  logic          perr;

  serial_frame_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (DW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rx_in_i     (rx),
    .data_out_o  (dout),
    .data_valid_o(dvalid),
    .data_ready_i(ready),
    .frame_err_o (ferr),
`ifdef SERIAL_RX_PARITY_EN
    .parity_err_o(perr),
`endif
    .overrun_o   (ovr)
  );

`ifndef SERIAL_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic          valid;
    logic          ferr;
    logic          ovr;
    logic          perr;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic prevValid = 1'b0;

  // One comparison: counts it and reports a miscompare.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one bit for a full bit time; entered and left just after a rising edge.
  task automatic holdBit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send one frame starting right now; when pushExp is set, queue the event
  // the receiver must show LAT cycles after the start-bit fall.
  task automatic applyStimulus(input logic [DW-1:0] data, input logic stopBit,
                               input logic parBit, input bit pushExp,
                               input logic [DW-1:0] expData, input logic expValid,
                               input logic expFerr, input logic expOvr);
    exp_t e;
    e.cyc   = cycle + LAT;
    e.data  = expData;
    e.valid = expValid;
    e.ferr  = expFerr;
    e.ovr   = expOvr;
    e.perr  = PAR_EN && stopBit && !expOvr && (parBit != ^data);
    if (pushExp) q.push_back(e);
    holdBit(1'b0);
    for (int i = 0; i < DW; i++) holdBit(data[i]);
`ifdef SERIAL_RX_PARITY_EN
    holdBit(parBit);
`endif
    holdBit(stopBit);
  endtask

  // Scoreboard monitor: any valid rise or flag pulse must match the head
  // of the expected queue, including the cycle it appears in.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && ((dvalid && !prevValid) || ferr || ovr || perr)) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_event: got data=0x%0h valid=%0b ferr=%0b ovr=%0b perr=%0b at cycle %0d, expected no event",
                 dout, dvalid, ferr, ovr, perr, cycle);
      end else begin
        e = q.pop_front();
        checkOutput("evt_data", 32'(dout), 32'(e.data));
        checkOutput("evt_flags", {28'd0, dvalid, ferr, ovr, perr},
                    {28'd0, e.valid, e.ferr, e.ovr, e.perr});
        checkOutput("evt_cycle", cycle, e.cyc);
      end
    end
    prevValid <= dvalid;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", {20'd0, dout, dvalid, ferr, ovr, perr}, 32'd0);
    rst_n = 1'b1;
    idle(20);

    $display("[TB] test 1: single byte 0xA5 with consumer ready");
    ready = 1'b1;
    applyStimulus(8'hA5, 1'b1, ^8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_valid_cleared", 32'(dvalid), 32'd0);
    idle(10);

    $display("[TB] test 2: back-to-back 0x3C, 0xC3 with consumer stalled");
    ready = 1'b0;
    applyStimulus(8'h3C, 1'b1, ^8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hC3, 1'b1, ^8'hC3, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
    checkOutput("t2_held_byte", {23'd0, dvalid, dout}, {23'd0, 1'b1, 8'h3C});
    ready = 1'b1;
    idle(10);

    $display("[TB] test 3: 0x55 with low stop bit, then 0x12");
    applyStimulus(8'h55, 1'b0, ^8'h55, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("t3_no_valid", 32'(dvalid), 32'd0);
    idle(20);
    applyStimulus(8'h12, 1'b1, ^8'h12, 1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    idle(10);

    $display("[TB] test 4: 4-cycle low glitch on idle line");
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    checkOutput("t4_glitch", {20'd0, dout, dvalid, ferr, ovr, perr},
                {20'd0, 8'h12, 4'b0000});

`ifdef SERIAL_RX_PARITY_EN
    $display("[TB] test 5: 0x07 with wrong parity bit");
    applyStimulus(8'h07, 1'b1, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
`else
    $display("[TB] test 5: 0x07");
    applyStimulus(8'h07, 1'b1, ^8'h07, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0);
`endif
    idle(10);

    $display("[TB] test 6: reset in the middle of 0xFF, then 0x81");
    ready = 1'b0;
    applyStimulus(8'h5A, 1'b1, ^8'h5A, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    idle(5);
    holdBit(1'b0);
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t6_reset", {20'd0, dout, dvalid, ferr, ovr, perr}, 32'd0);
    rst_n = 1'b1;
    idle(80);
    ready = 1'b1;
    applyStimulus(8'h81, 1'b1, ^8'h81, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0);
    idle(30);

    checkOutput("scoreboard_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
